// File: rtl/cond_logic_pkg.sv
// Shared definitions for the conditional-execution logic: condition encodings,
// flag bit positions and FlagW field indices. The decoder and ALU wrapper use them too.
package cond_logic_pkg;

    localparam int FLAG_WIDTH = 4;
    localparam int COND_WIDTH = 4;
    localparam logic [FLAG_WIDTH-1:0] DEFAULT_RESET_FLAGS = 4'b0000;

    // Flag vector order {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // FlagW bits: [1] updates N,Z and [0] updates C,V
    localparam int FLAGW_NZ = 1;
    localparam int FLAGW_CV = 0;

    // Condition field encodings
    localparam logic [COND_WIDTH-1:0] COND_EQ = 4'b0000;
    localparam logic [COND_WIDTH-1:0] COND_NE = 4'b0001;
    localparam logic [COND_WIDTH-1:0] COND_CS = 4'b0010;
    localparam logic [COND_WIDTH-1:0] COND_CC = 4'b0011;
    localparam logic [COND_WIDTH-1:0] COND_MI = 4'b0100;
    localparam logic [COND_WIDTH-1:0] COND_PL = 4'b0101;
    localparam logic [COND_WIDTH-1:0] COND_VS = 4'b0110;
    localparam logic [COND_WIDTH-1:0] COND_VC = 4'b0111;
    localparam logic [COND_WIDTH-1:0] COND_HI = 4'b1000;
    localparam logic [COND_WIDTH-1:0] COND_LS = 4'b1001;
    localparam logic [COND_WIDTH-1:0] COND_GE = 4'b1010;
    localparam logic [COND_WIDTH-1:0] COND_LT = 4'b1011;
    localparam logic [COND_WIDTH-1:0] COND_GT = 4'b1100;
    localparam logic [COND_WIDTH-1:0] COND_LE = 4'b1101;
    localparam logic [COND_WIDTH-1:0] COND_AL = 4'b1110;
    localparam logic [COND_WIDTH-1:0] COND_NV = 4'b1111;

endpackage

// File: rtl/cond_logic_if.sv
// Decoder/ALU-to-conditional-logic signal bundle. The master side drives the
// requests and ALU flags, while the slave side returns the gated commit strobes
// and the architectural flags.
interface cond_logic_if import cond_logic_pkg::*; ();

    logic                  En;
    logic [COND_WIDTH-1:0] Cond;
    logic [FLAG_WIDTH-1:0] ALUFlag;
    logic [1:0]            FlagW;
    logic                  PCS;
    logic                  RegW;
    logic                  MemW;

    logic                  PCSrc;
    logic                  RegWrite;
    logic                  MemWrite;
    logic                  CondEx;
    logic [FLAG_WIDTH-1:0] Flags;

    modport master (
        output En, Cond, ALUFlag, FlagW, PCS, RegW, MemW,
        input  PCSrc, RegWrite, MemWrite, CondEx, Flags
    );

    modport slave (
        input  En, Cond, ALUFlag, FlagW, PCS, RegW, MemW,
        output PCSrc, RegWrite, MemWrite, CondEx, Flags
    );

endinterface

// File: rtl/cond_logic_cond_check.sv
// Combinational condition evaluator. It checks the 4-bit condition field against
// the registered {N,Z,C,V} flags.
module cond_check import cond_logic_pkg::*; #(
    parameter int COND_W = COND_WIDTH,
    parameter int FLAG_W = FLAG_WIDTH
) (
    input  logic [COND_W-1:0] cond,
    input  logic [FLAG_W-1:0] flags,
    output logic              cond_ex
);

    logic n_flag, z_flag, c_flag, v_flag;
    logic ge_pass;

    assign n_flag  = flags[FLAG_N];
    assign z_flag  = flags[FLAG_Z];
    assign c_flag  = flags[FLAG_C];
    assign v_flag  = flags[FLAG_V];
    assign ge_pass = (n_flag == v_flag);

    // Decode the condition. The reserved encoding (1111) never executes.
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z_flag;
            COND_NE: cond_ex = ~z_flag;
            COND_CS: cond_ex = c_flag;
            COND_CC: cond_ex = ~c_flag;
            COND_MI: cond_ex = n_flag;
            COND_PL: cond_ex = ~n_flag;
            COND_VS: cond_ex = v_flag;
            COND_VC: cond_ex = ~v_flag;
            COND_HI: cond_ex = c_flag & ~z_flag;
            COND_LS: cond_ex = ~c_flag | z_flag;
            COND_GE: cond_ex = ge_pass;
            COND_LT: cond_ex = ~ge_pass;
            COND_GT: cond_ex = ~z_flag & ge_pass;
            COND_LE: cond_ex = z_flag | ~ge_pass;
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution unit. It holds the architectural flag register as two
// independently enabled fields, N/Z and C/V. It also gates the decoder's PC, register
// and memory write requests so that only instructions whose condition passes commit.
module cond_logic import cond_logic_pkg::*; #(
    parameter int                    FLAG_W      = FLAG_WIDTH,
    parameter int                    COND_W      = COND_WIDTH,
    parameter logic [FLAG_WIDTH-1:0] RESET_FLAGS = DEFAULT_RESET_FLAGS
) (
    input  logic        clk,
    input  logic        reset,
    cond_logic_if.slave bus
);

    logic [FLAG_W-1:0] flags;
    logic              cond_ex;
    logic [1:0]        field_we;

    // Condition is judged on the flags from before this instruction. The ALU
    // result is deliberately not bypassed here.
    cond_check #(
        .COND_W (COND_W),
        .FLAG_W (FLAG_W)
    ) u_cond_check (
        .cond    (bus.Cond),
        .flags   (flags),
        .cond_ex (cond_ex)
    );

    // A field is written only when the pipeline advances and the instruction passes.
    assign field_we = bus.FlagW & {2{bus.En & cond_ex}};

    // Field gi covers flag bits [2*gi+1 : 2*gi]. Field 1 is N,Z and field 0 is C,V.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_field
            logic [1:0] field_reg;

            // Reset overrides any pending write. Otherwise load the ALU flags when enabled.
            always_ff @(posedge clk) begin
                if (reset) begin
                    field_reg <= RESET_FLAGS[2*gi+1 -: 2];
                end else if (field_we[gi]) begin
                    field_reg <= bus.ALUFlag[2*gi+1 -: 2];
                end
            end

            assign flags[2*gi+1 -: 2] = field_reg;
        end
    endgenerate

    // Zero-latency commit gating.
    assign bus.PCSrc    = bus.PCS  & cond_ex;
    assign bus.RegWrite = bus.RegW & cond_ex;
    assign bus.MemWrite = bus.MemW & cond_ex;
    assign bus.CondEx   = cond_ex;
    assign bus.Flags    = flags;

endmodule
